mctrl: RTL and testbench

MCTRL -- requirements
Module: mctrl

---
 rtl/mctrl.sv | 167 ++++++++++++++++
 tb/tb_mctrl.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/mctrl.sv
// Multi-cycle MIPS-subset control FSM (FETCH/DECODE/EXEC/MEM/WB).
// Define BUS_TIMEOUT_EN to build the memory-access watchdog; TIMEOUT sets its limit.
module mctrl #(
    parameter int TIMEOUT = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] op,
    input  logic [5:0] funct,
    input  logic       zero,
    input  logic       mem_ack,
    output logic       mem_req,
    output logic       mem_we,
    output logic       pc_wr,
    output logic       ir_wr,
    output logic [1:0] pc_src,
    output logic       rf_wr,
    output logic       rf_dst,
    output logic       wd_sel,
    output logic       alu_src,
    output logic [1:0] alu_op,
    output logic [1:0] EOp,
    output logic [2:0] state,
    output logic       ill_instr,
    output logic       bus_err
);

    typedef enum logic [2:0] {
        FETCH  = 3'd0,
        DECODE = 3'd1,
        EXEC   = 3'd2,
        MEM    = 3'd3,
        WB     = 3'd4
    } state_t;

    state_t     state_q, state_d;
    logic [5:0] op_q, funct_q;
    logic [5:0] opCur, functCur;
    logic       isRtype, isAddu, isSubu, isOri, isLw, isSw, isBeq, isLui, isJ, legal;
    logic       timeout;

    // DECODE sees the live instruction bits; later states use the copy latched there.
    assign opCur    = (state_q == DECODE) ? op : op_q;
    assign functCur = (state_q == DECODE) ? funct : funct_q;

    assign isRtype = (opCur == 6'b000000);
    assign isAddu  = isRtype && (functCur == 6'b100001);
    assign isSubu  = isRtype && (functCur == 6'b100011);
    assign isOri   = (opCur == 6'b001101);
    assign isLw    = (opCur == 6'b100011);
    assign isSw    = (opCur == 6'b101011);
    assign isBeq   = (opCur == 6'b000100);
    assign isLui   = (opCur == 6'b001111);
    assign isJ     = (opCur == 6'b000010);
    assign legal   = isAddu | isSubu | isOri | isLw | isSw | isBeq | isLui | isJ;

`ifdef BUS_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);
    logic [CW-1:0] cnt_q, cnt_d;

    // Counts stalled request cycles; any ack or state change restarts it.
    assign timeout = (cnt_q == CW'(TIMEOUT));

    always_comb begin
        cnt_d = '0;
        if ((state_q == FETCH || state_q == MEM) && !mem_ack && !timeout)
            cnt_d = cnt_q + 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end
`else
    logic unused_timeout;
    assign unused_timeout = (TIMEOUT > 0);
    assign timeout        = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        case (state_q)
            FETCH:   if (timeout) state_d = FETCH;
                     else if (mem_ack) state_d = DECODE;
            DECODE:  state_d = legal ? EXEC : FETCH;
            EXEC:    if (isLw || isSw) state_d = MEM;
                     else if (isBeq || isJ) state_d = FETCH;
                     else state_d = WB;
            MEM:     if (timeout) state_d = FETCH;
                     else if (mem_ack) state_d = isLw ? WB : FETCH;
            WB:      state_d = FETCH;
            default: state_d = FETCH;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= FETCH;
            op_q    <= '0;
            funct_q <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == DECODE) begin
                op_q    <= op;
                funct_q <= funct;
            end
        end
    end

    // Outputs decode from the state so FETCH requests in the first cycle after reset;
    // reset masks them so an aborted access drops its request at once.
    always_comb begin
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        pc_wr     = 1'b0;
        ir_wr     = 1'b0;
        pc_src    = 2'b00;
        rf_wr     = 1'b0;
        rf_dst    = 1'b0;
        wd_sel    = 1'b0;
        alu_src   = 1'b0;
        alu_op    = 2'b00;
        EOp       = 2'b00;
        ill_instr = 1'b0;
        bus_err   = 1'b0;
        state     = state_q;
        if (!reset) begin
            if (state_q != FETCH) begin
                alu_src = isOri | isLw | isSw | isLui;
                EOp     = isOri ? 2'b01 : isLui ? 2'b10 : isBeq ? 2'b11 : 2'b00;
            end
            case (state_q)
                FETCH: begin
                    mem_req = !timeout;
                    ir_wr   = mem_ack && !timeout;
                    pc_wr   = mem_ack && !timeout;
                    bus_err = timeout;
                end
                DECODE: ill_instr = !legal;
                EXEC: begin
                    alu_op = isSubu || isBeq ? 2'b01 : isOri ? 2'b10 : isLui ? 2'b11 : 2'b00;
                    if (isBeq) begin
                        pc_wr  = zero;
                        pc_src = 2'b01;
                    end else if (isJ) begin
                        pc_wr  = 1'b1;
                        pc_src = 2'b10;
                    end
                end
                MEM: begin
                    mem_req = !timeout;
                    mem_we  = isSw && !timeout;
                    bus_err = timeout;
                end
                WB: begin
                    rf_wr  = 1'b1;
                    rf_dst = isRtype;
                    wd_sel = isLw;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mctrl.sv
// Scoreboard bench for mctrl: the driver queues hand-computed per-cycle outputs,
// a negedge monitor pops and compares them.
module tb_mctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] op, funct;
    logic       zero, mem_ack;
    logic       mem_req, mem_we, pc_wr, ir_wr, rf_wr, rf_dst, wd_sel, alu_src;
    logic       ill_instr, bus_err;
    logic [1:0] pc_src, alu_op, EOp;
    logic [2:0] state;

    mctrl #(.TIMEOUT(16)) dut (
        .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero),
        .mem_ack(mem_ack), .mem_req(mem_req), .mem_we(mem_we), .pc_wr(pc_wr),
        .ir_wr(ir_wr), .pc_src(pc_src), .rf_wr(rf_wr), .rf_dst(rf_dst),
        .wd_sel(wd_sel), .alu_src(alu_src), .alu_op(alu_op), .EOp(EOp),
        .state(state), .ill_instr(ill_instr), .bus_err(bus_err)
    );

    always #5 clk = ~clk;

    localparam logic [5:0] OP_R = 6'b000000, OP_ORI = 6'b001101, OP_LW = 6'b100011;
    localparam logic [5:0] OP_SW = 6'b101011, OP_BEQ = 6'b000100, OP_LUI = 6'b001111;
    localparam logic [5:0] OP_J = 6'b000010, F_ADDU = 6'b100001, F_SUBU = 6'b100011;

    typedef struct packed {
        logic [2:0] st;
        logic       mreq, mwe, pcw, irw;
        logic [1:0] psrc;
        logic       rfw, rfd, wds, als;
        logic [1:0] aop, eop;
        logic       ill, berr;
    } outs_t;

    typedef struct {
        string name;
        outs_t exp;
        bit    full;
    } sb_t;

    sb_t   sbq[$];
    int    testsRun = 0;
    int    testsFailed = 0;
    sb_t   monEntry;
    outs_t monAct, monMask;

    task automatic checkOutput(input string nm, input logic [31:0] act, input logic [31:0] exp);
        testsRun++;
        if (act !== exp) begin
            testsFailed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    function automatic outs_t o(input logic [2:0] st, input logic mreq, mwe, pcw, irw,
                                input logic [1:0] psrc, input logic rfw, rfd, wds, als,
                                input logic [1:0] aop, eop, input logic ill, berr);
        return {st, mreq, mwe, pcw, irw, psrc, rfw, rfd, wds, als, aop, eop, ill, berr};
    endfunction

    function automatic outs_t expZ();
        return o(3'd0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0);
    endfunction
    function automatic outs_t expF(input logic ack);
        return o(3'd0, 1, 0, ack, ack, 2'b00, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0);
    endfunction
    function automatic outs_t expD(input logic als, input logic [1:0] eop, input logic ill);
        return o(3'd1, 0, 0, 0, 0, 2'b00, 0, 0, 0, als, 2'b00, eop, ill, 0);
    endfunction
    function automatic outs_t expE(input logic pcw, input logic [1:0] psrc, input logic als,
                                   input logic [1:0] aop, eop);
        return o(3'd2, 0, 0, pcw, 0, psrc, 0, 0, 0, als, aop, eop, 0, 0);
    endfunction
    function automatic outs_t expM(input logic mreq, mwe, als, input logic [1:0] eop,
                                   input logic berr);
        return o(3'd3, mreq, mwe, 0, 0, 2'b00, 0, 0, 0, als, 2'b00, eop, 0, berr);
    endfunction
    function automatic outs_t expW(input logic rfd, wds, als, input logic [1:0] eop);
        return o(3'd4, 0, 0, 0, 0, 2'b00, 1, rfd, wds, als, 2'b00, eop, 0, 0);
    endfunction

    // Fields only meaningful in some states are ignored elsewhere unless full is set.
    function automatic outs_t careMask(input outs_t e, input bit full);
        outs_t m;
        m = '1;
        if (!full) begin
            if (e.st != 3'd4) begin
                m.rfd = 1'b0;
                m.wds = 1'b0;
            end
            if (e.st != 3'd2) m.aop = 2'b00;
            if (e.st == 3'd0) begin
                m.als = 1'b0;
                m.eop = 2'b00;
            end
        end
        return m;
    endfunction

    task automatic applyStimulus(input string nm, input logic ack, input logic z,
                                 input outs_t e, input bit full = 1'b0);
        mem_ack = ack;
        zero    = z;
        sbq.push_back('{name: nm, exp: e, full: full});
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (sbq.size() > 0) begin
            monEntry = sbq.pop_front();
            monAct   = {state, mem_req, mem_we, pc_wr, ir_wr, pc_src, rf_wr, rf_dst,
                        wd_sel, alu_src, alu_op, EOp, ill_instr, bus_err};
            monMask  = careMask(monEntry.exp, monEntry.full);
            checkOutput(monEntry.name, 32'(monAct & monMask), 32'(monEntry.exp & monMask));
        end
    end

    initial begin
        reset = 1'b1; op = '0; funct = '0; zero = 1'b0; mem_ack = 1'b1;
        @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) applyStimulus("reset hold", 1, 0, expZ(), 1'b1);
        reset = 1'b0;

        op = OP_R; funct = F_ADDU;
        applyStimulus("addu F", 1, 0, expF(1));
        applyStimulus("addu D", 1, 0, expD(0, 2'b00, 0));
        applyStimulus("addu E", 1, 0, expE(0, 2'b00, 0, 2'b00, 2'b00));
        applyStimulus("addu W", 1, 0, expW(1, 0, 0, 2'b00));

        op = OP_LW; funct = 6'h15;
        applyStimulus("lw F wait1", 0, 0, expF(0));
        applyStimulus("lw F wait2", 0, 0, expF(0));
        applyStimulus("lw F ack", 1, 0, expF(1));
        applyStimulus("lw D", 1, 0, expD(1, 2'b00, 0));
        applyStimulus("lw E", 1, 0, expE(0, 2'b00, 1, 2'b00, 2'b00));
        applyStimulus("lw M wait1", 0, 0, expM(1, 0, 1, 2'b00, 0));
        applyStimulus("lw M wait2", 0, 0, expM(1, 0, 1, 2'b00, 0));
        applyStimulus("lw M ack", 1, 0, expM(1, 0, 1, 2'b00, 0));
        applyStimulus("lw W", 1, 0, expW(0, 1, 1, 2'b00));

        op = OP_R; funct = F_SUBU;
        applyStimulus("subu F", 1, 0, expF(1));
        applyStimulus("subu D", 1, 0, expD(0, 2'b00, 0));
        applyStimulus("subu E", 1, 0, expE(0, 2'b00, 0, 2'b01, 2'b00));
        applyStimulus("subu W", 1, 0, expW(1, 0, 0, 2'b00));

        op = OP_ORI; funct = 6'h3f;
        applyStimulus("ori F", 1, 0, expF(1));
        applyStimulus("ori D", 1, 0, expD(1, 2'b01, 0));
        applyStimulus("ori E", 1, 0, expE(0, 2'b00, 1, 2'b10, 2'b01));
        applyStimulus("ori W", 1, 0, expW(0, 0, 1, 2'b01));

        op = OP_LUI;
        applyStimulus("lui F", 1, 0, expF(1));
        applyStimulus("lui D", 1, 0, expD(1, 2'b10, 0));
        applyStimulus("lui E", 1, 0, expE(0, 2'b00, 1, 2'b11, 2'b10));
        applyStimulus("lui W", 1, 0, expW(0, 0, 1, 2'b10));

        op = OP_BEQ;
        applyStimulus("beq1 F", 1, 0, expF(1));
        applyStimulus("beq1 D", 1, 0, expD(0, 2'b11, 0));
        applyStimulus("beq1 E", 1, 1, expE(1, 2'b01, 0, 2'b01, 2'b11));
        applyStimulus("beq0 F", 1, 0, expF(1));
        applyStimulus("beq0 D", 1, 0, expD(0, 2'b11, 0));
        applyStimulus("beq0 E", 1, 0, expE(0, 2'b01, 0, 2'b01, 2'b11));

        op = OP_R; funct = 6'b000000;
        applyStimulus("illR F", 1, 0, expF(1));
        applyStimulus("illR D", 1, 0, expD(0, 2'b00, 1));
        op = 6'b111111;
        applyStimulus("illOp F", 1, 0, expF(1));
        applyStimulus("illOp D", 1, 0, expD(0, 2'b00, 1));

        op = OP_J;
        applyStimulus("j F", 1, 0, expF(1));
        applyStimulus("j D", 1, 0, expD(0, 2'b00, 0));
        applyStimulus("j E", 1, 0, expE(1, 2'b10, 0, 2'b00, 2'b00));

        op = OP_SW;
        applyStimulus("sw F", 1, 0, expF(1));
        applyStimulus("sw D", 1, 0, expD(1, 2'b00, 0));
        applyStimulus("sw E", 1, 0, expE(0, 2'b00, 1, 2'b00, 2'b00));
        applyStimulus("sw M ack", 1, 0, expM(1, 1, 1, 2'b00, 0));

        applyStimulus("swTo F", 1, 0, expF(1));
        applyStimulus("swTo D", 1, 0, expD(1, 2'b00, 0));
        applyStimulus("swTo E", 1, 0, expE(0, 2'b00, 1, 2'b00, 2'b00));
`ifdef BUS_TIMEOUT_EN
        for (int i = 0; i < 16; i++) applyStimulus("swTo M stall", 0, 0, expM(1, 1, 1, 2'b00, 0));
        applyStimulus("swTo bus_err", 0, 0, expM(0, 0, 1, 2'b00, 1));
`else
        for (int i = 0; i < 110; i++) applyStimulus("swTo M hold", 0, 0, expM(1, 1, 1, 2'b00, 0));
        applyStimulus("swTo M late ack", 1, 0, expM(1, 1, 1, 2'b00, 0));
`endif
        op = OP_J;
        applyStimulus("after sw F", 1, 0, expF(1));
        applyStimulus("after sw D", 1, 0, expD(0, 2'b00, 0));
        applyStimulus("after sw E", 1, 0, expE(1, 2'b10, 0, 2'b00, 2'b00));

        op = OP_SW;
        applyStimulus("swRst F", 1, 0, expF(1));
        applyStimulus("swRst D", 1, 0, expD(1, 2'b00, 0));
        applyStimulus("swRst E", 1, 0, expE(0, 2'b00, 1, 2'b00, 2'b00));
        mem_ack = 1'b0;
        #1;
        checkOutput("swRst in MEM", 32'({state, mem_req, mem_we}), 32'({3'd3, 1'b1, 1'b1}));
        reset = 1'b1;
        #1;
        checkOutput("async reset drop", 32'({state, mem_req, mem_we}), 32'({3'd0, 1'b0, 1'b0}));
        @(posedge clk);
        #1;
        applyStimulus("swRst hold1", 1, 0, expZ(), 1'b1);
        applyStimulus("swRst hold2", 1, 0, expZ(), 1'b1);
        reset = 1'b0;
        op = OP_R; funct = F_ADDU;
        applyStimulus("post rst F", 1, 0, expF(1));
        applyStimulus("post rst D", 1, 0, expD(0, 2'b00, 0));
        applyStimulus("post rst E", 1, 0, expE(0, 2'b00, 0, 2'b00, 2'b00));
        applyStimulus("post rst W", 1, 0, expW(1, 0, 0, 2'b00));

        @(negedge clk);
        @(negedge clk);
        checkOutput("scoreboard drained", 32'(sbq.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
